// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types, defaults and round-robin pick helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Search upward from last_grant+1 (mod num_req); fixed 8-slot loop bounds the hardware.
  function automatic logic [2:0] rr_pick(
    input logic [7:0]  valid,
    input logic [2:0]  last_grant,
    input int unsigned num_req
  );
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = (32'(last_grant) + k) % num_req;
      if (!found && (k <= num_req) && valid[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_comb.sv
// ============================================================================
// rr_pick_comb : combinational round-robin priority picker
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick_comb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any_valid
);

  logic [7:0] w_valid_ext;
  logic [2:0] w_last_ext;
  logic [2:0] w_pick;

  assign w_valid_ext = 8'(i_valid);
  assign w_last_ext  = 3'(i_last_grant);
  assign w_pick      = rr_pick(w_valid_ext, w_last_ext, NUM_REQ);
  assign o_idx       = ID_W'(w_pick);
  assign o_any_valid = |i_valid;

endmodule

`default_nettype wire

// File: rtl/uart_tx_wr_arbiter.sv
// ============================================================================
// uart_tx_wr_arbiter : packet-atomic round-robin arbiter for the TX FIFO write port
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_wr_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_W  = UART_DATA_W,
  parameter int NUM_REQ = 4,
  parameter int MAX_PKT = 16,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(MAX_PKT + 1)
) (
  input  logic                      clk_wr,
  input  logic                      reset,
  input  logic                      i_arb_en,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_last,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wr_en,
  output logic [DATA_W-1:0]         o_fifo_data,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy,
  output logic                      o_trunc_err
);

  localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(MAX_PKT - 1);
  localparam logic [ID_W-1:0]  c_LAST_INIT = ID_W'(NUM_REQ - 1);

  arb_state_e       r_state;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_last_grant;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_trunc_err;

  arb_state_e       w_state_nxt;
  logic [ID_W-1:0]  w_grant_nxt;
  logic [ID_W-1:0]  w_last_grant_nxt;
  logic [CNT_W-1:0] w_beat_cnt_nxt;
  logic             w_trunc_nxt;

  logic [ID_W-1:0]  w_pick;
  logic             w_any_valid;
  logic             w_xfer;
  logic             w_sel_last;

  rr_pick_comb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_valid      (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_idx        (w_pick),
    .o_any_valid  (w_any_valid)
  );

  always_ff @(posedge clk_wr or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= c_LAST_INIT;
      r_beat_cnt   <= '0;
      r_trunc_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_trunc_err  <= w_trunc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_trunc_nxt      = 1'b0;
    w_xfer           = 1'b0;
    w_sel_last       = 1'b0;
    o_req_ready      = '0;
    o_fifo_wr_en     = 1'b0;
    o_fifo_data      = '0;

    case (r_state)
      IDLE: begin
        if (i_arb_en && w_any_valid) begin
          w_state_nxt    = LOCKED;
          w_grant_nxt    = w_pick;
          w_beat_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        // full gates the write here so the FIFO never sees wr_en while full
        w_xfer                  = i_req_valid[r_grant_id] & ~i_fifo_full;
        w_sel_last              = i_req_last[r_grant_id];
        o_req_ready[r_grant_id] = ~i_fifo_full;
        o_fifo_wr_en            = w_xfer;
        o_fifo_data             = i_req_data[r_grant_id*DATA_W +: DATA_W];
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (w_sel_last || (r_beat_cnt == c_CNT_LAST)) begin
            w_state_nxt      = IDLE;
            w_last_grant_nxt = r_grant_id;
            w_trunc_nxt      = ~w_sel_last;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_grant_id  = r_grant_id;
  assign o_busy      = (r_state == LOCKED);
  assign o_trunc_err = r_trunc_err;

endmodule

`default_nettype wire
